// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer and its cpu-facing interface.
package instr_sequencer_pkg;

    typedef logic [15:0] instr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_WLEAVE,
        S_WDONE,
        S_DONE,
        S_ERROR
    } seq_state_e;

    // Bit positions inside the {N,V,Z} status vector
    localparam int NVZ_N = 2;
    localparam int NVZ_V = 1;
    localparam int NVZ_Z = 0;

endpackage

// File: rtl/instr_sequencer_if.sv
// Load/start/wait handshake between the sequencer (master) and the cpu (slave).
interface instr_sequencer_if;
    import instr_sequencer_pkg::*;

    logic       cpu_load;
    logic       cpu_s;
    instr_t     cpu_in;
    logic       cpu_w;
    instr_t     cpu_out;
    logic [2:0] cpu_nvz;

    modport master (output cpu_load, cpu_s, cpu_in, input cpu_w, cpu_out, cpu_nvz);
    modport slave  (input cpu_load, cpu_s, cpu_in, output cpu_w, cpu_out, cpu_nvz);

endinterface

// File: rtl/instr_sequencer_prog_ram.sv
// Program store: one write port, registered read with enable. The array itself is
// never reset so a program survives reset; only the read register is cleared.
module prog_ram
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  instr_t        wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output instr_t        rdata_o
);

    instr_t mem_q [DEPTH];
    instr_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register holds between reads so the cpu sees a stable instruction
    always_ff @(posedge clk) begin
        if (!rst_ni)   rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Feeds a stored program to the cpu one instruction at a time over load/s,
// waits on the cpu w flag, and captures out/NVZ after each instruction.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  instr_t        prog_wdata,
    input  logic [AW:0]   prog_len,
    input  logic          run,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic [AW-1:0] pc,
    output logic [AW:0]   instr_count,
    output instr_t        last_out,
    output logic [2:0]    last_nvz,
    instr_sequencer_if.master cpu
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX    = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    seq_state_e    state_q, state_d;
    logic [AW:0]   len_q, len_d, count_q, count_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [TW-1:0] timer_q, timer_d;
    instr_t        last_out_q, last_out_d;
    logic [2:0]    last_nvz_q, last_nvz_d;
    logic          busy_q, done_q, err_q, load_q, s_q;
    logic          idle_like;
    instr_t        rdata;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);

    prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .rst_ni  (reset),
        .we_i    (prog_we && idle_like),
        .waddr_i (prog_addr),
        .wdata_i (prog_wdata),
        .re_i    (state_q == S_FETCH),
        .raddr_i (pc_q),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        count_d    = count_q;
        pc_d       = pc_q;
        timer_d    = timer_q;
        last_out_d = last_out_q;
        last_nvz_d = last_nvz_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (run) begin
                    len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                    pc_d    = '0;
                    count_d = '0;
                    state_d = (len_d == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: begin
                timer_d = '0;
                state_d = S_WLEAVE;
            end
            // Both wait states share one timer so a stalled handshake always ends in ERROR
            S_WLEAVE, S_WDONE: begin
                if (state_q == S_WLEAVE && !cpu.cpu_w) begin
                    timer_d = timer_q + 1'b1;
                    state_d = S_WDONE;
                end else if (state_q == S_WDONE && cpu.cpu_w) begin
                    last_out_d = cpu.cpu_out;
                    last_nvz_d = cpu.cpu_nvz;
                    count_d    = count_q + 1'b1;
                    if (count_d == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timer_q == TMAX) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status and handshake outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            count_q    <= '0;
            pc_q       <= '0;
            timer_q    <= '0;
            last_out_q <= '0;
            last_nvz_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            load_q     <= 1'b0;
            s_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            timer_q    <= timer_d;
            last_out_q <= last_out_d;
            last_nvz_q <= last_nvz_d;
            busy_q     <= !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERROR);
            load_q     <= (state_d == S_LOAD) || (state_d == S_START);
            s_q        <= (state_d == S_START);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err_timeout  = err_q;
    assign pc           = pc_q;
    assign instr_count  = count_q;
    assign last_out     = last_out_q;
    assign last_nvz     = last_nvz_q;
    assign cpu.cpu_load = load_q;
    assign cpu.cpu_s    = s_q;
    assign cpu.cpu_in   = rdata;

endmodule
